// File: rtl/mem_xkx32_arb_if.sv
// ---------------------------------------------------------------------------
// mem_xkx32_arb_if
//   Bundles both requester ports and the single-port RAM connection of the
//   xKx32 memory arbiter.
//   Requester side (per port x = 0/1):
//     reqx    request, held with its attributes until gntx
//     wex     byte-lane write enables, all zero = read
//     addrx   word address
//     wdatax  write data
//     gntx    access accepted this cycle (combinational)
//     rvalidx read data valid for port x, one cycle after a read grant
//     rdata   read data shared by both ports, qualify with rvalid0/1
//   Memory side:
//     mem_ce, mem_wen, mem_addr, mem_din  towards the RAM
//     mem_qout                            registered RAM output, 1-cycle latency
//   Modports: slave = arbiter, master = requesters plus memory model.
// ---------------------------------------------------------------------------
interface mem_xkx32_arb_if #(
  parameter int T_MSZ       = 12,
  parameter int WIDTH_DATA  = 32,
  parameter int CNT_CHANNLS = 4
);
  logic                   req0;
  logic                   req1;
  logic [CNT_CHANNLS-1:0] we0;
  logic [CNT_CHANNLS-1:0] we1;
  logic [T_MSZ-1:0]       addr0;
  logic [T_MSZ-1:0]       addr1;
  logic [WIDTH_DATA-1:0]  wdata0;
  logic [WIDTH_DATA-1:0]  wdata1;
  logic                   gnt0;
  logic                   gnt1;
  logic                   rvalid0;
  logic                   rvalid1;
  logic [WIDTH_DATA-1:0]  rdata;
  logic                   mem_ce;
  logic [CNT_CHANNLS-1:0] mem_wen;
  logic [T_MSZ-1:0]       mem_addr;
  logic [WIDTH_DATA-1:0]  mem_din;
  logic [WIDTH_DATA-1:0]  mem_qout;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_qout,
    output gnt0, gnt1, rvalid0, rvalid1, rdata,
           mem_ce, mem_wen, mem_addr, mem_din
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_qout,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata,
           mem_ce, mem_wen, mem_addr, mem_din
  );
endinterface

// File: rtl/mem_xkx32_arb.sv
// ---------------------------------------------------------------------------
// mem_xkx32_arb
//   Two-requester round-robin arbiter in front of one single-port xKx32
//   byte-lane RAM. Port 0 is the FT601 streaming side, port 1 the local
//   core/register side. One access is granted per cycle, ownership is bounded
//   by MAX_BURST while the other port waits, and read data returns one cycle
//   after the grant.
//   Ports:
//     clk   single clock, rising edge
//     rstn  asynchronous active-low reset
//     bus   mem_xkx32_arb_if.slave: requester ports and RAM connection
//   Parameters:
//     T_MSZ      address width (RAM holds 2**T_MSZ words)
//     MAX_BURST  consecutive accesses by one owner while the other requests
//                (1..256)
// ---------------------------------------------------------------------------
module mem_xkx32_arb #(
  parameter int T_MSZ     = 12,
  parameter int MAX_BURST = 8
) (
  input  logic             clk,
  input  logic             rstn,
  mem_xkx32_arb_if.slave   bus
);
  localparam int WIDTH_DATA  = 32;
  localparam int CNT_CHANNLS = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  // Last burst count value that still allows the owner to keep the memory.
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  logic [1:0] state_q, state_d;
  logic       last_owner_q, last_owner_d;   // 1 = port 1 owned last
  logic [7:0] burst_cnt_q, burst_cnt_d;
  logic       rvalid0_q, rvalid1_q;

  logic                   gnt0, gnt1;
  logic                   own_req, other_req, own_id;
  logic [T_MSZ-1:0]       addr_sel;
  logic [WIDTH_DATA-1:0]  din_sel;
  logic [CNT_CHANNLS-1:0] wen_sel;

  // Grants decode from the registered state, so they drop the moment reset
  // asserts and can never be active together.
  assign gnt0 = (state_q == ST_OWN0) & bus.req0;
  assign gnt1 = (state_q == ST_OWN1) & bus.req1;

  assign addr_sel = (state_q == ST_OWN1) ? bus.addr1  : bus.addr0;
  assign din_sel  = (state_q == ST_OWN1) ? bus.wdata1 : bus.wdata0;
  assign wen_sel  = gnt0 ? bus.we0 : (gnt1 ? bus.we1 : '0);

  assign bus.gnt0     = gnt0;
  assign bus.gnt1     = gnt1;
  assign bus.mem_ce   = gnt0 | gnt1;
  assign bus.mem_wen  = wen_sel;
  assign bus.mem_addr = addr_sel;
  assign bus.mem_din  = din_sel;
  assign bus.rdata    = bus.mem_qout;
  assign bus.rvalid0  = rvalid0_q;
  assign bus.rvalid1  = rvalid1_q;

  // Requests seen from the current owner's point of view.
  assign own_id    = (state_q == ST_OWN1);
  assign own_req   = own_id ? bus.req1 : bus.req0;
  assign other_req = own_id ? bus.req0 : bus.req1;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and no latch is inferred.
    state_d      = state_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    case (state_q)
      ST_IDLE: begin
        burst_cnt_d = '0;
        if (bus.req0 && bus.req1) begin
          state_d = last_owner_q ? ST_OWN0 : ST_OWN1;
        end else if (bus.req0) begin
          state_d = ST_OWN0;
        end else if (bus.req1) begin
          state_d = ST_OWN1;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (!other_req) begin
          // Uncontended streaming never consumes burst budget.
          burst_cnt_d = '0;
          if (!own_req) begin
            state_d      = ST_IDLE;
            last_owner_d = own_id;
          end
        end else if (own_req && (burst_cnt_q < BURST_LAST)) begin
          burst_cnt_d = burst_cnt_q + 8'd1;
        end else begin
          // Hand over directly: the waiting port is granted next cycle.
          state_d      = own_id ? ST_OWN0 : ST_OWN1;
          last_owner_d = own_id;
          burst_cnt_d  = '0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        burst_cnt_d = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      last_owner_q <= 1'b1;   // port 0 wins the first tie
      burst_cnt_q  <= '0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      rvalid0_q    <= gnt0 & (bus.we0 == '0);
      rvalid1_q    <= gnt1 & (bus.we1 == '0);
    end
  end
endmodule
